// File: rtl/seq_adder_ctrl_if.sv
// Handshake bundle for seq_adder_ctrl: operand request side and result side.
// The master is the requester/consumer and the slave is the sequencer.
interface seq_adder_ctrl_if #(
  parameter int W = 16
);
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Ci;
  logic         SUB;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] S;
  logic         Co;
  logic         OV;

  modport master (
    output IN_VALID, A, B, Ci, SUB, OUT_READY,
    input  IN_READY, OUT_VALID, S, Co, OV
  );

  modport slave (
    input  IN_VALID, A, B, Ci, SUB, OUT_READY,
    output IN_READY, OUT_VALID, S, Co, OV
  );
endinterface

// File: rtl/seq_adder_ctrl.sv
// W-bit add/subtract built from one reused 4-bit ripple slice, LS nibble first,
// with the carry registered between passes. W must be a multiple of 4.
module seq_adder_ctrl #(
  parameter int W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  seq_adder_ctrl_if.slave   bus
);
  localparam int NSLICE = W / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  work_q, work_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  s_q, s_d;
  logic          co_q, co_d;
  logic          ov_q, ov_d;

  logic [3:0]    a_nib, b_nib;
  logic [4:0]    slice;
  logic [W-1:0]  work_upd;

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.OUT_VALID = (state_q == DONE);
  assign bus.S         = s_q;
  assign bus.Co        = co_q;
  assign bus.OV        = ov_q;

  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    work_upd = work_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (int'(k_q) == i) begin
        a_nib = opa_q[4*i +: 4];
        b_nib = opb_q[4*i +: 4];
      end
    end
    slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry_q};
    for (int i = 0; i < NSLICE; i++) begin
      if (int'(k_q) == i) work_upd[4*i +: 4] = slice[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    work_d  = work_q;
    k_d     = k_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          // Subtract is folded into an add: A + ~B + ~Ci.
          opa_d   = bus.A;
          opb_d   = bus.SUB ? ~bus.B : bus.B;
          carry_d = bus.SUB ? ~bus.Ci : bus.Ci;
          work_d  = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d  = work_upd;
        carry_d = slice[4];
        if (k_q == KLAST) begin
          s_d     = work_upd;
          co_d    = slice[4];
          ov_d    = (opa_q[W-1] == opb_q[W-1]) && (work_upd[W-1] != opa_q[W-1]);
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
      k_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      work_q  <= work_d;
      k_q     <= k_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end
endmodule
